// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide execution unit.
//   Radix-2 shift-add multiply (MUL/MLA/UMULL/UMLAL/SMULL/SMLAL) and restoring
//   unsigned divide, one iteration per clock, WIDTH iterations per operation.
// Ports:
//   clk, reset              clock (rising edge), asynchronous active-high reset
//   Start                   command strobe, sampled only while idle
//   IsMul, IsLongMul        multiply command / 2*WIDTH-bit result request
//   MulFunct[2:0]           multiply variant (bit0 accumulate, bit1 signed, bit2 long)
//   IsDiv                   unsigned divide SrcA / SrcB
//   SrcA, SrcB              multiplicand/dividend, multiplier/divisor
//   AccHi, AccLo            accumulate operand
//   ResultHi, ResultLo      registered result (product or remainder/quotient)
//   Busy, Done              unit occupied / one-cycle completion pulse
//   ResN, ResZ              registered sign and zero flags of the result
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic             IsMul,
  input  logic             IsLongMul,
  input  logic [2:0]       MulFunct,
  input  logic             IsDiv,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [WIDTH-1:0] AccHi,
  input  logic [WIDTH-1:0] AccLo,
  output logic [WIDTH-1:0] ResultHi,
  output logic [WIDTH-1:0] ResultLo,
  output logic             Busy,
  output logic             Done,
  output logic             ResN,
  output logic             ResZ
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e               state_q;
  logic [CntW-1:0]      count_q;
  logic                 is_mul_q;
  logic                 long_q;
  logic                 neg_q;
  logic [2*WIDTH-1:0]   acc_q;
  // Multiply: a_q multiplicand (shifts left), b_q multiplier (shifts right), p_q product.
  // Divide:   a_q[W-1:0] divisor, b_q dividend shifting out / quotient shifting in,
  //           p_q[W-1:0] partial remainder.
  logic [2*WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]     b_q;
  logic [2*WIDTH-1:0]   p_q;

  logic                 sgn_in;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [2*WIDTH-1:0]   mul_p_step;
  logic [WIDTH:0]       trial;
  logic                 qbit;
  logic [WIDTH-1:0]     rem_step, quo_step;
  logic [2*WIDTH-1:0]   prod_fin;
  logic [WIDTH-1:0]     res_hi_d, res_lo_d;
  logic                 res_n_d, res_z_d;

  always_comb begin
    sgn_in = MulFunct[1];
    // Negating the most-negative value yields itself, which read unsigned is 2^(W-1).
    mag_a  = (sgn_in && SrcA[WIDTH-1]) ? -SrcA : SrcA;
    mag_b  = (sgn_in && SrcB[WIDTH-1]) ? -SrcB : SrcB;

    mul_p_step = p_q + (b_q[0] ? a_q : '0);

    // Partial remainder stays below the divisor, so W+1 bits hold the signed difference.
    // With a zero divisor every bit subtracts and the remainder ends up equal to the dividend.
    trial    = {p_q[WIDTH-1:0], b_q[WIDTH-1]} - {1'b0, a_q[WIDTH-1:0]};
    qbit     = ~trial[WIDTH];
    rem_step = qbit ? trial[WIDTH-1:0] : {p_q[WIDTH-2:0], b_q[WIDTH-1]};
    quo_step = {b_q[WIDTH-2:0], qbit};

    prod_fin = (neg_q ? -mul_p_step : mul_p_step) + acc_q;

    res_hi_d = '0;
    res_lo_d = '0;
    res_n_d  = 1'b0;
    res_z_d  = 1'b0;
    if (is_mul_q) begin
      res_lo_d = prod_fin[WIDTH-1:0];
      if (long_q) begin
        res_hi_d = prod_fin[2*WIDTH-1:WIDTH];
        res_n_d  = prod_fin[2*WIDTH-1];
        res_z_d  = (prod_fin == '0);
      end else begin
        res_n_d  = prod_fin[WIDTH-1];
        res_z_d  = (prod_fin[WIDTH-1:0] == '0);
      end
    end else begin
      res_hi_d = rem_step;
      res_lo_d = quo_step;
      res_n_d  = quo_step[WIDTH-1];
      res_z_d  = (quo_step == '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      count_q  <= '0;
      is_mul_q <= 1'b0;
      long_q   <= 1'b0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      p_q      <= '0;
      ResultHi <= '0;
      ResultLo <= '0;
      ResN     <= 1'b0;
      ResZ     <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (Start && (IsMul || IsDiv)) begin
            state_q  <= StRun;
            Busy     <= 1'b1;
            count_q  <= '0;
            is_mul_q <= IsMul;
            // A long result needs both the request and a long function code.
            long_q   <= IsMul & IsLongMul & MulFunct[2];
            neg_q    <= IsMul & sgn_in & (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
            p_q      <= '0;
            if (IsMul) begin
              a_q <= {{WIDTH{1'b0}}, mag_a};
              b_q <= mag_b;
              if (MulFunct[0]) begin
                acc_q <= (IsLongMul && MulFunct[2]) ? {AccHi, AccLo} : {{WIDTH{1'b0}}, AccLo};
              end else begin
                acc_q <= '0;
              end
            end else begin
              a_q   <= {{WIDTH{1'b0}}, SrcB};
              b_q   <= SrcA;
              acc_q <= '0;
            end
          end
        end
        StRun: begin
          if (is_mul_q) begin
            p_q <= mul_p_step;
            a_q <= a_q << 1;
            b_q <= b_q >> 1;
          end else begin
            p_q[WIDTH-1:0] <= rem_step;
            b_q            <= quo_step;
          end
          count_q <= count_q + CntW'(1);
          if (count_q == LastCnt) begin
            state_q  <= StDone;
            Done     <= 1'b1;
            ResultHi <= res_hi_d;
            ResultLo <= res_lo_d;
            ResN     <= res_n_d;
            ResZ     <= res_z_d;
          end
        end
        StDone: begin
          state_q <= StIdle;
          Done    <= 1'b0;
          Busy    <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          Done    <= 1'b0;
          Busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (WIDTH = 32).
module tb_muldiv_unit;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          Start;
  logic          IsMul;
  logic          IsLongMul;
  logic [2:0]    MulFunct;
  logic          IsDiv;
  logic [W-1:0]  SrcA, SrcB, AccHi, AccLo;
  logic [W-1:0]  ResultHi, ResultLo;
  logic          Busy, Done, ResN, ResZ;

  int n_assert = 0;
  int n_fail   = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .Start     (Start),
    .IsMul     (IsMul),
    .IsLongMul (IsLongMul),
    .MulFunct  (MulFunct),
    .IsDiv     (IsDiv),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .AccHi     (AccHi),
    .AccLo     (AccLo),
    .ResultHi  (ResultHi),
    .ResultLo  (ResultLo),
    .Busy      (Busy),
    .Done      (Done),
    .ResN      (ResN),
    .ResZ      (ResZ)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Entered at a negedge; issues one command and checks result, latency and the Done pulse.
  // Leaves at the idle negedge right after Done, so a following call is back-to-back.
  task automatic run_op(input string tag, input logic mul, input logic lng,
                        input logic [2:0] fn, input logic dv,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ahi, input logic [W-1:0] alo,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo,
                        input logic en, input logic ez);
    int cyc;
    IsMul = mul; IsLongMul = lng; MulFunct = fn; IsDiv = dv;
    SrcA = a; SrcB = b; AccHi = ahi; AccLo = alo;
    Start = 1'b1;
    @(negedge clk);
    // Scramble inputs after acceptance; the unit must use its latched copies.
    Start = 1'b0; IsMul = 1'b0; IsDiv = 1'b0; MulFunct = 3'b010;
    SrcA = 32'hDEAD_BEEF; SrcB = 32'h1234_5678; AccHi = 32'h5555_5555; AccLo = 32'hAAAA_AAAA;
    cyc = 0;
    while (Done !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, ".latency"}, 64'(cyc), 64'(W));
    chk({tag, ".hi"}, 64'(ResultHi), 64'(ehi));
    chk({tag, ".lo"}, 64'(ResultLo), 64'(elo));
    chk({tag, ".n"}, 64'(ResN), 64'(en));
    chk({tag, ".z"}, 64'(ResZ), 64'(ez));
    chk({tag, ".busy_done"}, 64'(Busy), 64'd1);
    @(negedge clk);
    chk({tag, ".done_pulse"}, 64'(Done), 64'd0);
    chk({tag, ".idle"}, 64'(Busy), 64'd0);
    chk({tag, ".lo_hold"}, 64'(ResultLo), 64'(elo));
  endtask

  initial begin
    int dones, done_at, gaps;
    reset = 1'b1; Start = 1'b0; IsMul = 1'b0; IsLongMul = 1'b0; MulFunct = 3'b000;
    IsDiv = 1'b0; SrcA = '0; SrcB = '0; AccHi = '0; AccLo = '0;
    @(negedge clk);
    chk("reset.hi", 64'(ResultHi), 64'd0);
    chk("reset.lo", 64'(ResultLo), 64'd0);
    chk("reset.flags", {60'd0, Busy, Done, ResN, ResZ}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op("umull_max", 1, 1, 3'b100, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0,
           32'hFFFF_FFFE, 32'h0000_0001, 1, 0);
    run_op("smull_m2x3", 1, 1, 3'b110, 0, 32'hFFFF_FFFE, 32'd3, 0, 0,
           32'hFFFF_FFFF, 32'hFFFF_FFFA, 1, 0);
    run_op("smlal_zero", 1, 1, 3'b111, 0, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd6,
           32'd0, 32'd0, 0, 1);
    run_op("mla", 1, 0, 3'b001, 0, 32'd7, 32'd6, 32'hFFFF_FFFF, 32'd5,
           32'd0, 32'h0000_002F, 0, 0);
    run_op("mul_wrap", 1, 0, 3'b000, 0, 32'h8000_0000, 32'd2, 0, 0,
           32'd0, 32'd0, 0, 1);
    run_op("smull_minneg", 1, 1, 3'b110, 0, 32'h8000_0000, 32'h8000_0000, 0, 0,
           32'h4000_0000, 32'd0, 0, 0);
    run_op("umlal", 1, 1, 3'b101, 0, 32'h0001_0000, 32'h0001_0000, 32'd2, 32'hFFFF_FFFF,
           32'd3, 32'hFFFF_FFFF, 0, 0);
    run_op("div_100_7", 0, 0, 3'b000, 1, 32'd100, 32'd7, 0, 0,
           32'd2, 32'd14, 0, 0);
    run_op("div_by_zero", 0, 0, 3'b000, 1, 32'd5, 32'd0, 0, 0,
           32'd5, 32'hFFFF_FFFF, 1, 0);
    run_op("div_small", 0, 0, 3'b000, 1, 32'd3, 32'd10, 0, 0,
           32'd3, 32'd0, 0, 1);
    run_op("mul_wins", 1, 0, 3'b000, 1, 32'd7, 32'd6, 0, 0,
           32'd0, 32'd42, 0, 0);

    // Start without a command is ignored.
    IsMul = 1'b0; IsDiv = 1'b0; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    chk("nocmd.busy", 64'(Busy), 64'd0);
    chk("nocmd.lo", 64'(ResultLo), 64'd42);

    // Start held high through the whole run: no restart, one Done, Busy continuous.
    IsMul = 1'b1; IsLongMul = 1'b1; MulFunct = 3'b100; SrcA = 32'd3; SrcB = 32'd5;
    Start = 1'b1;
    dones = 0; done_at = -1; gaps = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (Done === 1'b1) begin
        dones++;
        done_at = k;
        Start = 1'b0;
      end else if (dones == 0 && Busy !== 1'b1) begin
        gaps++;
      end
    end
    chk("held.dones", 64'(dones), 64'd1);
    chk("held.latency", 64'(done_at), 64'(W));
    chk("held.busy_gaps", 64'(gaps), 64'd0);
    chk("held.lo", 64'(ResultLo), 64'd15);
    chk("held.idle", 64'(Busy), 64'd0);

    // Reset in the middle of a divide.
    IsMul = 1'b0; IsDiv = 1'b1; SrcA = 32'd100; SrcB = 32'd7; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    repeat (10) @(negedge clk);
    chk("midrst.busy_before", 64'(Busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("midrst.lo", 64'(ResultLo), 64'd0);
    chk("midrst.hi", 64'(ResultHi), 64'd0);
    chk("midrst.flags", {60'd0, Busy, Done, ResN, ResZ}, 64'd0);
    #1 reset = 1'b0;
    @(negedge clk);
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (Done === 1'b1) dones++;
    end
    chk("midrst.no_done", 64'(dones), 64'd0);
    run_op("after_reset_mla", 1, 0, 3'b001, 0, 32'd7, 32'd6, 0, 32'd5,
           32'd0, 32'h0000_002F, 0, 0);
    run_op("after_reset_div", 0, 0, 3'b000, 1, 32'hFFFF_FFFF, 32'd1, 0, 0,
           32'd0, 32'hFFFF_FFFF, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
